bus_io_port: RTL
================

Name: bus_io_port

Overview:
- Memory-mapped I/O responder on the processor's shared address/data bus (addr, inout data, rd, wr).
- The processor is the bus initiator; this block is the responder for a two-address window.
- Processor writes are buffered into a TX FIFO, which drains to an external consumer over a valid/ready handshake.
- External bytes are accepted over valid/ready into an RX FIFO, which the processor reads.
- At top level, the memory's rd and wr must be qualified with !hit.

Parameters:
- AWIDTH, 5, bus address width
- DWIDTH, 8, bus data width
- BASE_ADDR, 5'h1E, data register address; status register is at BASE_ADDR+1
- DEPTH, 4, entries per FIFO (power of 2, ≥2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- addr  input  AWIDTH  bus address
- data  inout  DWIDTH  shared data bus; driven only when rd && hit, else high-Z
- rd  input  1  bus read strobe; may be held for multiple cycles per access
- wr  input  1  bus write strobe; one write per cycle asserted
- hit  output  1  combinational: addr == BASE_ADDR or BASE_ADDR+1
- out_data  output  DWIDTH  TX FIFO head
- out_valid  output  1  TX FIFO non-empty
- out_ready  input  1  consumer accepts out_data this cycle
- in_data  input  DWIDTH  incoming byte
- in_valid  input  1  in_data valid
- in_ready  output  1  RX FIFO not full

Behaviour:
- Clock, reset, decode and bus drive:
  - One clock: clk. Reset rst is synchronous and active-high.
  - When rst=1 at a rising edge: both FIFOs empty, pointers and counts = 0, sticky flags = 0, rd_q = 0.
  - Values after reset: out_valid=0, out_data=0, in_ready=1.
  - rst dominates every other event in the same cycle; data in flight is discarded.
  - DATA = BASE_ADDR. STAT = BASE_ADDR+1.
  - Address arithmetic wraps mod 2^AWIDTH.
  - data bus drive is combinational: rd && addr==DATA gives the RX head (0 if RX empty); rd && addr==STAT gives the status word; otherwise 'bz.
  - Status word, zero-extended to DWIDTH: bit0 rx_nonempty, bit1 tx_full, bit2 tx_empty, bit3 rx_ovf (sticky), bit4 tx_ovf (sticky).
- TX push:
  - Occurs on each cycle with wr && addr==DATA.
  - If TX is full and there is no same-cycle drain: the byte is dropped, tx_ovf is set, and the count is unchanged.
- TX drain:
  - A transfer occurs when out_valid && out_ready.
  - Simultaneous push and drain: both happen, count unchanged; legal even when full.
- TX latency:
  - A write on cycle N makes out_valid=1 at N+1 if TX was empty.
  - out_data is the storage entry at the read pointer.
  - out_data holds stable while out_valid && !out_ready.
- wr to STAT: ignored.
- RX push:
  - Occurs when in_valid && in_ready; in_ready = (rx_count != DEPTH).
  - in_valid while full does not push and does not set rx_ovf.
  - rx_ovf is set only by a processor read of DATA while RX is empty.
- RX pop:
  - rd may be held for several cycles per access.
  - A register rd_q records rd && addr==DATA from the previous cycle.
  - Exactly one pop occurs on the cycle where rd_q=1 and (rd && addr==DATA)=0, i.e. at the end of the access, if RX was non-empty when the access started.
  - The head value stays stable on the bus for the whole access.
  - Simultaneous RX push and pop: both happen, count unchanged.
- Sticky clear:
  - rx_ovf and tx_ovf clear at the end of a STAT read access (same falling-edge rule as RX pop).
  - Setting takes priority over clearing in the same cycle.
- Wrap: pointers are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits, range 0..DEPTH.
- Simultaneous rd and wr to the window: wr is processed and rd is processed; no mutual interaction.

Test Plan:
- Reset → out_valid=0, in_ready=1, status word 8'h04.
- Four wr to DATA (8'hA1,A2,A3,A4) with out_ready=0 → tx_full, status 8'h02. Fifth wr of 8'hA5 → dropped, status 8'h12. Then out_ready=1 → out_data sequence A1,A2,A3,A4, then out_valid=0.
- Push 8'h5C via in_valid. rd held 3 cycles at DATA → bus reads 8'h5C all three cycles; exactly one pop; status then reads 8'h04.
- Read DATA with RX empty → bus 8'h00, no pop, rx_ovf=1. Next STAT read returns 8'h0C; the following STAT read returns 8'h04.
- TX full and out_ready=1 with simultaneous wr of 8'h77 → no overflow, count stays 4; 8'h77 emerges last.
- rst asserted mid-drain with 3 TX entries and 2 RX entries → next cycle out_valid=0, in_ready=1, status 8'h04. rd to a non-window address → data is 'bz and hit=0.

Source files
------------

// File: rtl/bus_io_port.sv
// Memory-mapped byte port: a data/status register pair on the shared CPU bus,
// backed by a TX FIFO (CPU -> consumer) and an RX FIFO (producer -> CPU).
module bus_io_port #(
  parameter int                AWIDTH    = 5,
  parameter int                DWIDTH    = 8,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 5'h1E,
  parameter int                DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  inout  wire  [DWIDTH-1:0] data,
  input  logic              rd,
  input  logic              wr,
  output logic              hit,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam int                PW        = $clog2(DEPTH);
  localparam int                CW        = PW + 1;
  localparam logic [AWIDTH-1:0] DATA_ADDR = BASE_ADDR;
  localparam logic [AWIDTH-1:0] STAT_ADDR = BASE_ADDR + AWIDTH'(1);
  localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);

  logic [DWIDTH-1:0] tx_mem [DEPTH];
  logic [DWIDTH-1:0] rx_mem [DEPTH];
  logic [PW-1:0]     tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0]     tx_count, rx_count;
  logic              rx_ovf, tx_ovf;
  logic              rd_q, stat_q, pop_armed;

  logic              data_sel, stat_sel, rd_data, rd_stat, wr_data;
  logic              tx_full, tx_empty, rx_empty;
  logic              tx_push, tx_drain, tx_drop;
  logic              rx_push, rx_pop, rx_ovf_set, sticky_clr;
  logic [DWIDTH-1:0] status, rd_word;

  assign data_sel = (addr == DATA_ADDR);
  assign stat_sel = (addr == STAT_ADDR);
  assign hit      = data_sel | stat_sel;
  assign rd_data  = rd && data_sel;
  assign rd_stat  = rd && stat_sel;
  assign wr_data  = wr && data_sel;

  assign tx_full   = (tx_count == FULL_CNT);
  assign tx_empty  = (tx_count == '0);
  assign rx_empty  = (rx_count == '0);
  assign out_valid = !tx_empty;
  assign out_data  = tx_mem[tx_rd_ptr];
  assign in_ready  = (rx_count != FULL_CNT);

  // A full TX FIFO still accepts a write when the head leaves in the same cycle.
  assign tx_drain = out_valid && out_ready;
  assign tx_push  = wr_data && (!tx_full || tx_drain);
  assign tx_drop  = wr_data && tx_full && !tx_drain;

  // RX pops on the trailing edge of a DATA read, so a held rd sees one stable byte.
  assign rx_push    = in_valid && in_ready;
  assign rx_pop     = rd_q && !rd_data && pop_armed;
  assign rx_ovf_set = rd_data && !rd_q && rx_empty;
  assign sticky_clr = stat_q && !rd_stat;

  assign status  = DWIDTH'({tx_ovf, rx_ovf, tx_empty, tx_full, !rx_empty});
  assign rd_word = data_sel ? (rx_empty ? '0 : rx_mem[rx_rd_ptr]) : status;
  assign data    = (rd && hit) ? rd_word : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem[i] <= '0;
        rx_mem[i] <= '0;
      end
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_count  <= '0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      rd_q      <= 1'b0;
      stat_q    <= 1'b0;
      pop_armed <= 1'b0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr_ptr] <= data;
        tx_wr_ptr         <= tx_wr_ptr + PW'(1);
      end
      if (tx_drain) tx_rd_ptr <= tx_rd_ptr + PW'(1);
      case ({tx_push, tx_drain})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase

      if (rx_push) begin
        rx_mem[rx_wr_ptr] <= in_data;
        rx_wr_ptr         <= rx_wr_ptr + PW'(1);
      end
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase

      if (tx_drop)         tx_ovf <= 1'b1;
      else if (sticky_clr) tx_ovf <= 1'b0;
      if (rx_ovf_set)      rx_ovf <= 1'b1;
      else if (sticky_clr) rx_ovf <= 1'b0;

      rd_q      <= rd_data;
      stat_q    <= rd_stat;
      // Latch at access start whether there is a byte to pop when the access ends.
      pop_armed <= rd_data ? (rd_q ? pop_armed : !rx_empty) : 1'b0;
    end
  end

endmodule
